uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver for the TP2 serial path. It replaces the fixed 8N1 receiver and takes a one-cycle oversample tick from the shared baud-rate generator. It synchronises the line, qualifies the start bit at mid-bit and samples data LSB-first. It supports configurable data width, parity mode and stop-bit count, and reports parity, framing and break conditions with each received character.

## Interface
- `NB_DATA`, 8: data bits per character; legal range 5..9.
- `PARITY`, 2'b00: 00 none, 01 even, 10 odd; 11 is treated as none.
- `NB_STOP`, 1: stop bits; legal values 1 or 2.
- `OVERSAMPLE`, 16: ticks per bit; even, at least 4.

- `clk`  in  1: system clock; all logic on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- `i_tick`  in  1: oversample tick, one-cycle pulse at BAUD_RATE*OVERSAMPLE.
- `i_rx`  in  1: serial line, asynchronous, idle high.
- `o_rx_data`  out  NB_DATA: last received character.
- `o_rx_done`  out  1: one-cycle pulse when a character completes.
- `o_parity_err`  out  1: parity mismatch on the last character.
- `o_frame_err`  out  1: a stop bit was sampled 0 on the last character.
- `o_break`  out  1: the last character was a break (all bits 0).

## Operation
- `i_rx` passes through a 2-FF synchroniser (`rx_s`). Both flops reset to 1.
- Tick counter `tcnt`: $clog2(OVERSAMPLE) bits. It advances only on cycles with `i_tick`=1 and clears on every state change.
- Bit counter: $clog2(NB_DATA+1) bits.
- Shift register: data enters LSB first.
- FSM states:
  - IDLE: `i_tick` is ignored. If `rx_s`=0, go to START with `tcnt`=0.
  - START: on the tick where `tcnt`==OVERSAMPLE/2-1, sample `rx_s`.
    - Sample is 1: false start; go to IDLE with no outputs.
    - Sample is 0: go to DATA with bit counter 0.
  - DATA: on the tick where `tcnt`==OVERSAMPLE-1, shift in `rx_s`.
    - After NB_DATA bits, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: sample at `tcnt`==OVERSAMPLE-1.
    - Even mode: error if XOR(data, parity bit) is 1.
    - Odd mode: error if XOR(data, parity bit) is 0.
  - STOP: sample at `tcnt`==OVERSAMPLE-1, NB_STOP times.
    - Any 0 sample sets the internal frame flag.
    - On the last sample: pulse `o_rx_done`; load `o_rx_data`, `o_parity_err`, `o_frame_err` and `o_break`.
    - Go to WAIT_HIGH if the frame flag is set, otherwise to IDLE.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one `o_rx_done`.
- Break condition: data==0, parity bit (if enabled)==0, and frame flag set.
  - When set, `o_frame_err`=1 and `o_break`=1 together.
  - `o_parity_err` is still computed normally.
- Status outputs hold their value until the next `o_rx_done`.
- The receiver always accepts the next character. There is no back-pressure, and an unread character is overwritten.

## Timing
- Reset values: `o_rx_data`=0, `o_rx_done`=0, `o_parity_err`=0, `o_frame_err`=0, `o_break`=0. The FSM resets to IDLE and all counters to 0.
- Reset mid-frame: reset takes effect immediately and the partial character is discarded with no `o_rx_done`. The first falling edge after release starts a fresh frame.
- Line to FSM latency: 2 clk (synchroniser).
- START to `o_rx_done`, counted in ticks after entering START: OVERSAMPLE/2 + (NB_DATA + P + NB_STOP)*OVERSAMPLE, where P=1 if parity is enabled, else 0.
- `o_rx_done` occurs in the clk cycle following the tick of the final stop sample.
  - It is high for exactly one clk.
  - Data and flags are valid in that same cycle.
- Only `i_tick` cycles advance `tcnt`. If two ticks arrive back-to-back, each counts.
- A falling edge that arrives in the same cycle as the IDLE transition starts a frame on the next cycle; no character is lost between back-to-back frames.

## Test plan
- 8N1, OVERSAMPLE=16, send 0x55 then 0xA3 back-to-back → two `o_rx_done` pulses; data 0x55 then 0xA3; all error flags 0.
- PARITY=01, send 0xA3 with parity bit 1 → `o_rx_done`, data 0xA3, `o_parity_err`=1. Resend 0xA3 with parity bit 0 → `o_parity_err`=0.
- NB_STOP=2, send 0x3C with the second stop bit 0 → data 0x3C, `o_frame_err`=1, `o_break`=0; the next 0x0F is received clean.
- Hold `i_rx` low for 20 bit times, then release and send 0x0F:
  - First response: exactly one `o_rx_done` with data 0x00, `o_frame_err`=1, `o_break`=1.
  - Second response: data 0x0F with all flags cleared.
- Low glitch on `i_rx` lasting 4 ticks → no `o_rx_done`; FSM returns to IDLE; a following 0x81 is received correctly.
- Pull `i_rst_n` low during data bit 3 of 0xC3 → all outputs 0 and no `o_rx_done`. After release, send 0xC3 → data 0xC3, all flags 0.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with configurable data width, parity, stop bits and break detection
module uart_rx_os #(
    parameter int         NB_DATA    = 8,
    parameter logic [1:0] PARITY     = 2'b00,
    parameter int         NB_STOP    = 1,
    parameter int         OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NB_DATA - 1);
    localparam logic [BW-1:0] S_LAST = BW'(NB_STOP - 1);
    localparam logic PAR_EN  = (PARITY == 2'b01) || (PARITY == 2'b10);
    localparam logic PAR_ODD = (PARITY == 2'b10);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

    state_t state, state_n;
    logic rx_meta, rx_s;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] bcnt;
    logic [NB_DATA-1:0] shreg;
    logic par_bit, frame, frame_nxt, done, samp_mid, samp_end;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    assign samp_mid  = i_tick && (tcnt == T_HALF);
    assign samp_end  = i_tick && (tcnt == T_END);
    assign frame_nxt = frame || !rx_s;
    assign done      = (state == STOP) && samp_end && (bcnt == S_LAST);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = rx_s ? IDLE : START;
            START:     state_n = samp_mid ? (rx_s ? IDLE : DATA) : START;
            DATA:      state_n = (samp_end && bcnt == B_LAST) ? (PAR_EN ? PAR : STOP) : DATA;
            PAR:       state_n = samp_end ? STOP : PAR;
            STOP:      state_n = done ? (frame_nxt ? WAIT_HIGH : IDLE) : STOP;
            WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end

    // A stop-bit 0 latches the frame flag; break additionally needs all-zero data and parity.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            tcnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            frame        <= 1'b0;
            o_rx_data    <= '0;
            o_rx_done    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            state     <= state_n;
            o_rx_done <= done;
            if (state_n != state)
                tcnt <= '0;
            else if (i_tick && state != IDLE && state != WAIT_HIGH)
                tcnt <= (tcnt == T_END) ? '0 : tcnt + 1'b1;
            if (state_n != state)
                bcnt <= '0;
            else if (samp_end && (state == DATA || state == STOP))
                bcnt <= bcnt + 1'b1;
            if (state == DATA && samp_end)
                shreg <= {rx_s, shreg[NB_DATA-1:1]};
            if (state == IDLE)
                par_bit <= 1'b0;
            else if (state == PAR && samp_end)
                par_bit <= rx_s;
            if (state == IDLE)
                frame <= 1'b0;
            else if (state == STOP && samp_end && !rx_s)
                frame <= 1'b1;
            if (done) begin
                o_rx_data    <= shreg;
                o_parity_err <= PAR_EN && ((^shreg ^ par_bit) ^ PAR_ODD);
                o_frame_err  <= frame_nxt;
                o_break      <= (shreg == '0) && !par_bit && frame_nxt;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench over 8N1, 8E1 and 8N2 receiver instances
module tb_uart_rx_os;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] div = 2'd0;
    logic tick;
    logic [2:0] rx = 3'b111;
    logic [2:0][7:0] rdat;
    logic [2:0] rdone, rpe, rfe, rbr;
    int checks = 0;
    int failures = 0;
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign tick = (div == 2'd3);

    uart_rx_os u_n1 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[0]),
        .o_rx_data(rdat[0]), .o_rx_done(rdone[0]), .o_parity_err(rpe[0]),
        .o_frame_err(rfe[0]), .o_break(rbr[0])
    );
    uart_rx_os #(.PARITY(2'b01)) u_e1 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[1]),
        .o_rx_data(rdat[1]), .o_rx_done(rdone[1]), .o_parity_err(rpe[1]),
        .o_frame_err(rfe[1]), .o_break(rbr[1])
    );
    uart_rx_os #(.NB_STOP(2)) u_n2 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[2]),
        .o_rx_data(rdat[2]), .o_rx_done(rdone[2]), .o_parity_err(rpe[2]),
        .o_frame_err(rfe[2]), .o_break(rbr[2])
    );

    task automatic push(input int d, input logic [7:0] v, input logic pe, input logic fe, input logic br);
        case (d)
            0: q0.push_back({v, pe, fe, br});
            1: q1.push_back({v, pe, fe, br});
            default: q2.push_back({v, pe, fe, br});
        endcase
    endtask

    task automatic chk_rx(input int d, input logic [10:0] act);
        logic [10:0] exp;
        logic have;
        have = 1'b0;
        exp = '0;
        case (d)
            0: if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL rx%0d unexpected done: got data/pe/fe/br=%h/%b%b%b, none required", d, act[10:3], act[2], act[1], act[0]);
        end else if (act !== exp) begin
            failures++;
            $display("FAIL rx%0d char: got data/pe/fe/br=%h/%b%b%b, required %h/%b%b%b",
                     d, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    always @(negedge clk)
        for (int d = 0; d < 3; d++)
            if (rdone[d] === 1'b1) chk_rx(d, {rdat[d], rpe[d], rfe[d], rbr[d]});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
        end
    endtask

    task automatic bit_out(input int d, input logic b);
        rx[d] = b;
        wait_ticks(16);
    endtask

    // par < 0 means no parity bit; s2 is the second stop bit when nstop == 2
    task automatic send(input int d, input logic [7:0] v, input int par, input int nstop, input logic s2);
        bit_out(d, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(d, v[i]);
        if (par >= 0) bit_out(d, par[0]);
        bit_out(d, 1'b1);
        if (nstop == 2) bit_out(d, s2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " data"}, {24'd0, rdat[0]}, 32'd0);
        check({tag, " done"}, {31'd0, rdone[0]}, 32'd0);
        check({tag, " pe"}, {31'd0, rpe[0]}, 32'd0);
        check({tag, " fe"}, {31'd0, rfe[0]}, 32'd0);
        check({tag, " br"}, {31'd0, rbr[0]}, 32'd0);
    endtask

    initial begin
        logic [7:0] c3;
        c3 = 8'hC3;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        wait_ticks(20);

        push(0, 8'h55, 0, 0, 0);
        push(0, 8'hA3, 0, 0, 0);
        send(0, 8'h55, -1, 1, 1'b1);
        send(0, 8'hA3, -1, 1, 1'b1);
        wait_ticks(16);

        push(1, 8'hA3, 1, 0, 0);
        send(1, 8'hA3, 1, 1, 1'b1);
        push(1, 8'hA3, 0, 0, 0);
        send(1, 8'hA3, 0, 1, 1'b1);
        wait_ticks(16);

        push(2, 8'h3C, 0, 1, 0);
        send(2, 8'h3C, -1, 2, 1'b0);
        bit_out(2, 1'b1);
        push(2, 8'h0F, 0, 0, 0);
        send(2, 8'h0F, -1, 2, 1'b1);
        wait_ticks(16);

        push(0, 8'h00, 0, 1, 1);
        rx[0] = 1'b0;
        wait_ticks(20 * 16);
        bit_out(0, 1'b1);
        push(0, 8'h0F, 0, 0, 0);
        send(0, 8'h0F, -1, 1, 1'b1);
        wait_ticks(16);

        rx[0] = 1'b0;
        wait_ticks(4);
        rx[0] = 1'b1;
        wait_ticks(32);
        push(0, 8'h81, 0, 0, 0);
        send(0, 8'h81, -1, 1, 1'b1);
        wait_ticks(16);

        bit_out(0, 1'b0);
        for (int i = 0; i < 3; i++) bit_out(0, c3[i]);
        rx[0] = c3[3];
        wait_ticks(8);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(32);
        push(0, 8'hC3, 0, 0, 0);
        send(0, 8'hC3, -1, 1, 1'b1);
        wait_ticks(32);

        check("rx0 pending", q0.size(), 0);
        check("rx1 pending", q1.size(), 0);
        check("rx2 pending", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
